// File: rtl/cpu_sequencer_pkg.sv
// Shared CPU encodings: opcodes (also used by the control decoder) and sequencer states.
// Latency: none, constants only.
// Backpressure: n/a.
package cpu_pkg;

    // Opcodes as found in IR[15:13]
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ANDI  = 3'b001;
    localparam logic [2:0] OP_ORI   = 3'b010;
    localparam logic [2:0] OP_ADDI  = 3'b011;
    localparam logic [2:0] OP_SLTI  = 3'b100;
    localparam logic [2:0] OP_LW    = 3'b101;
    localparam logic [2:0] OP_SW    = 3'b110;
    localparam logic [2:0] OP_BNE   = 3'b111;

    // Sequencer state encoding; also exported on Phase for debug
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd7;

    // Loads and stores take the extra MEM phase
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Counts consecutive unready memory-request cycles; flags when WAIT_LIMIT is reached.
// Latency: expired is a registered-count compare, valid the cycle after the last increment.
// Backpressure: none; saturates at WAIT_LIMIT until cleared.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count up and hold at the limit
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb phase sequencer generating datapath enables and memory handshake.
// Latency: 3 (BNE), 4 (ALU, SW), 5 (LW) cycles per instruction plus one per memory wait cycle.
// Backpressure: holds MemReq until MemReady; faults after WAIT_LIMIT unready cycles.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic [2:0]  OPCODE,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemWe,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        MdrWrite,
    output logic        RegWriteEn,
    output logic        Retire,
    output logic [15:0] InstrCount,
    output logic        Fault,
    output logic [2:0]  Phase
);

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        wait_expired;
    logic        wait_clear;

    // Strobes and next state; strobes are Moore except the MemReady- and Zero-gated ones
    always_comb begin
        state_d    = state_q;
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        MdrWrite   = 1'b0;
        RegWriteEn = 1'b0;
        Retire     = 1'b0;
        Fault      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (op_q == OP_BNE) begin
                    PCWrite = ~Zero;
                    PCSrc   = 1'b1;
                    Retire  = 1'b1;
                end else if (is_mem_op(op_q)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                MemReq = 1'b1;
                MemWe  = (op_q == OP_SW);
                if (MemReady) begin
                    if (op_q == OP_SW) begin
                        Retire = 1'b1;
                    end else begin
                        MdrWrite = 1'b1;
                        state_d  = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                RegWriteEn = 1'b1;
                Retire     = 1'b1;
            end
            ST_FAULT: begin
                Fault = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Run is only consulted at retire, so a dropped Run never aborts an instruction
        if (Retire) state_d = Run ? ST_FETCH : ST_IDLE;
    end

    // Opcode is captured once in DECODE; IR-driven OPCODE may change afterwards
    always_comb begin
        op_d = (state_q == ST_DECODE) ? OPCODE : op_q;
    end

    // Retired-instruction counter, wraps naturally at 16 bits
    always_comb begin
        instr_count_d = Retire ? (instr_count_q + 16'd1) : instr_count_q;
    end

    // State, captured opcode and retire count registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_RTYPE;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Wait count restarts on each completed transfer and on every phase change
    assign wait_clear = (MemReq && MemReady) || (state_d != state_q);

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (wait_clear),
        .count_en (MemReq && !MemReady),
        .expired  (wait_expired)
    );

    assign InstrCount = instr_count_q;
    assign Phase      = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-cycle expected strobe vectors via a scoreboard queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic [2:0]  OPCODE = 3'd0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic        MemReq, MemWe, IRWrite, PCWrite, PCSrc, MdrWrite, RegWriteEn, Retire, Fault;
    logic [15:0] InstrCount;
    logic [2:0]  Phase;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_count = 16'd0;
    logic [11:0] exp_q[$];
    int          ncyc;

    cpu_sequencer #(.WAIT_LIMIT(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Run        (Run),
        .OPCODE     (OPCODE),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .MdrWrite   (MdrWrite),
        .RegWriteEn (RegWriteEn),
        .Retire     (Retire),
        .InstrCount (InstrCount),
        .Fault      (Fault),
        .Phase      (Phase)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Vector order: Phase, MemReq, MemWe, IRWrite, PCWrite, PCSrc, MdrWrite, RegWriteEn, Retire, Fault
    function automatic logic [11:0] outs();
        return {Phase, MemReq, MemWe, IRWrite, PCWrite, PCSrc, MdrWrite, RegWriteEn, Retire, Fault};
    endfunction

    // Drive one cycle of inputs, push its expected outputs, compare at the falling edge
    task automatic cyc(input string tag, input logic rdy, input logic run, input logic [2:0] opc,
                       input logic z, input logic [11:0] e);
        MemReady = rdy;
        Run      = run;
        OPCODE   = opc;
        Zero     = z;
        exp_q.push_back(e);
        @(negedge Clock);
        check_val(tag, {4'd0, outs()}, {4'd0, exp_q.pop_front()});
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_cycle(input logic run);
        cyc("idle", 1'b0, run, 3'd0, 1'b0, {3'd0, 9'b0});
    endtask

    // One whole instruction; fw/mw are wait cycles before MemReady in FETCH/MEM
    task automatic do_instr(input string tag, input logic [2:0] op, input int fw, input int mw,
                            input logic z, input logic run_after, output int n);
        logic r;
        logic [2:0] bad;
        n = 0;
        for (int i = 0; i <= fw; i++) begin
            r = (i == fw);
            cyc({tag, "_fetch"}, r, 1'b1, op, 1'b0,
                {3'd1, 1'b1, 1'b0, r, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
            n++;
        end
        cyc({tag, "_decode"}, 1'b0, 1'b1, op, 1'b0, {3'd2, 9'b0});
        n++;
        bad = ~op;  // OPCODE changes after DECODE; the captured copy must be used
        if (op == OP_BNE) begin
            cyc({tag, "_exec"}, 1'b0, run_after, bad, z,
                {3'd3, 1'b0, 1'b0, 1'b0, ~z, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
            n++;
        end else begin
            cyc({tag, "_exec"}, 1'b0, run_after, bad, z, {3'd3, 9'b0});
            n++;
            if (op == OP_LW || op == OP_SW) begin
                for (int i = 0; i <= mw; i++) begin
                    r = (i == mw);
                    cyc({tag, "_mem"}, r, run_after, bad, z,
                        {3'd4, 1'b1, (op == OP_SW), 1'b0, 1'b0, 1'b0,
                         (op == OP_LW) && r, 1'b0, (op == OP_SW) && r, 1'b0});
                    n++;
                end
            end
            if (op != OP_SW) begin
                cyc({tag, "_wb"}, 1'b0, run_after, bad, z,
                    {3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
                n++;
            end
        end
        exp_count = exp_count + 16'd1;
        check_val({tag, "_count"}, InstrCount, exp_count);
    endtask

    initial begin
        // Reset state
        #3;
        check_val("rst_outs", {4'd0, outs()}, 16'd0);
        check_val("rst_count", InstrCount, 16'd0);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // ALU, load and branches with Run held high (back-to-back)
        do_instr("addi", OP_ADDI, 0, 0, 1'b0, 1'b1, ncyc);
        check_val("addi_cycles", ncyc[15:0], 16'd4);
        do_instr("lw", OP_LW, 3, 2, 1'b0, 1'b1, ncyc);
        check_val("lw_cycles", ncyc[15:0], 16'd10);
        do_instr("bne_taken", OP_BNE, 0, 0, 1'b0, 1'b1, ncyc);
        check_val("bne_cycles", ncyc[15:0], 16'd3);
        do_instr("bne_nt", OP_BNE, 0, 0, 1'b1, 1'b1, ncyc);
        check_val("bne_nt_cycles", ncyc[15:0], 16'd3);
        // Ready arriving in the limit cycle completes normally
        do_instr("sw_limit", OP_SW, 4, 0, 1'b0, 1'b1, ncyc);
        check_val("sw_limit_cycles", ncyc[15:0], 16'd8);
        do_instr("andi", OP_ANDI, 0, 0, 1'b1, 1'b1, ncyc);
        do_instr("ori", OP_ORI, 1, 0, 1'b0, 1'b1, ncyc);
        do_instr("slti", OP_SLTI, 0, 0, 1'b0, 1'b1, ncyc);
        do_instr("lw_mwait", OP_LW, 0, 4, 1'b0, 1'b1, ncyc);
        check_val("lw_mwait_cycles", ncyc[15:0], 16'd9);
        // Run dropped from EXEC onward: instruction completes, then IDLE
        do_instr("rtype", OP_RTYPE, 0, 0, 1'b0, 1'b0, ncyc);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // Reset pulsed in the middle of a waiting FETCH
        MemReady = 1'b0;
        #3;
        check_val("fetch_req", {4'd0, outs()}, {4'd0, 3'd1, 1'b1, 8'b0});
        Reset = 1'b1;
        #1;
        check_val("rst_mid_outs", {4'd0, outs()}, 16'd0);
        check_val("rst_mid_count", InstrCount, 16'd0);
        exp_count = 16'd0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        Run = 1'b0;

        // SW whose data phase never completes: faults after WAIT_LIMIT+1 MEM cycles
        idle_cycle(1'b1);
        cyc("flt_fetch", 1'b1, 1'b1, OP_SW, 1'b0, {3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 5'b0});
        cyc("flt_decode", 1'b0, 1'b1, OP_SW, 1'b0, {3'd2, 9'b0});
        cyc("flt_exec", 1'b0, 1'b1, OP_SW, 1'b0, {3'd3, 9'b0});
        for (int i = 0; i < 5; i++)
            cyc("flt_mem", 1'b0, 1'b1, OP_SW, 1'b0, {3'd4, 1'b1, 1'b1, 7'b0});
        for (int i = 0; i < 4; i++)
            cyc("flt_hold", 1'b1, 1'b1, OP_SW, 1'b0, {3'd7, 8'b0, 1'b1});
        check_val("flt_count", InstrCount, 16'd0);
        Reset = 1'b1;
        #1;
        check_val("flt_rst_outs", {4'd0, outs()}, 16'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        MemReady = 1'b0;
        Run = 1'b0;

        // Long back-to-back BNE run
        idle_cycle(1'b1);
        for (int k = 0; k < 1000; k++)
            do_instr("bne_run", OP_BNE, 0, 0, k[0], (k != 999), ncyc);
        check_val("bne_run_count", InstrCount, 16'd1000);
        idle_cycle(1'b0);

        // Preload the counter to 0xFFFF to keep the wrap check short
        force dut.instr_count_q = 16'hFFFF;
        @(posedge Clock);
        #1;
        release dut.instr_count_q;
        exp_count = 16'hFFFF;
        idle_cycle(1'b0);
        check_val("preload", InstrCount, 16'hFFFF);
        idle_cycle(1'b1);
        do_instr("bne_wrap", OP_BNE, 0, 0, 1'b1, 1'b0, ncyc);
        check_val("wrap_zero", InstrCount, 16'h0000);
        idle_cycle(1'b0);

        check_val("sb_empty", exp_q.size() > 0 ? 16'd1 : 16'd0, 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
